// File: rtl/uart_mem_cmd_bridge.sv
// ============================================================================
// uart_mem_cmd_bridge : UART byte-stream command engine for burst memory
//   read/write; optional inter-byte timeout enabled by macro CMD_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_mem_cmd_bridge #(
    parameter int ADDR_BYTES     = 4,
    parameter int ADDR_W         = 23,
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wdata,
    input  logic [8*DATA_BYTES-1:0] mem_rdata,
    input  logic                    mem_ack,
    output logic                    busy,
    output logic                    overrun
);

    localparam int         DW      = 8 * DATA_BYTES;
    localparam int         CNT_MAX = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int         CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] AB_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DATA_BYTES - 1);
    localparam logic [7:0] OP_WR   = 8'h56;
    localparam logic [7:0] OP_RD   = 8'h55;
    localparam logic [7:0] RSP_ACK = 8'hA5;
    localparam logic [7:0] RSP_NAK = 8'hEE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_LEN   = 3'd1,
        GET_ADDR  = 3'd2,
        GET_DATA  = 3'd3,
        MEM_REQ   = 3'd4,
        SEND_DATA = 3'd5,
        SEND_RESP = 3'd6
    } state_t;

    state_t          state;
    logic            is_wr;
    logic [7:0]      words_left;
    logic [CW-1:0]   byte_cnt;
    logic [DW-1:0]   rd_buf;
    logic            timeout_hit;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          in_get;

    assign in_get      = (state == GET_LEN) || (state == GET_ADDR) || (state == GET_DATA);
    assign timeout_hit = in_get && !rx_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counts idle cycles between frame bytes; any accepted byte restarts it.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            to_cnt <= '0;
        end else if (!in_get || rx_valid || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            words_left <= '0;
            byte_cnt   <= '0;
            rd_buf     <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (timeout_hit) begin
                tx_data  <= RSP_NAK;
                tx_valid <= 1'b1;
                byte_cnt <= '0;
                state    <= SEND_RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            busy <= 1'b1;
                            if (rx_data == OP_WR || rx_data == OP_RD) begin
                                is_wr    <= (rx_data == OP_WR);
                                mem_addr <= '0;
                                state    <= GET_LEN;
                            end else begin
                                tx_data  <= RSP_NAK;
                                tx_valid <= 1'b1;
                                state    <= SEND_RESP;
                            end
                        end
                    end

                    GET_LEN: begin
                        if (rx_valid) begin
                            words_left <= rx_data;
                            byte_cnt   <= '0;
                            state      <= GET_ADDR;
                        end
                    end

                    GET_ADDR: begin
                        if (rx_valid) begin
                            // Bytes landing above ADDR_W have no target bits and vanish.
                            for (int i = 0; i < ADDR_W; i++) begin
                                if (i / 8 == int'(byte_cnt)) begin
                                    mem_addr[i] <= rx_data[i % 8];
                                end
                            end
                            if (byte_cnt == AB_LAST) begin
                                byte_cnt <= '0;
                                if (is_wr) begin
                                    state <= GET_DATA;
                                end else begin
                                    mem_req <= 1'b1;
                                    mem_we  <= 1'b0;
                                    state   <= MEM_REQ;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end

                    GET_DATA: begin
                        if (rx_valid) begin
                            mem_wdata[int'(byte_cnt)*8 +: 8] <= rx_data;
                            if (byte_cnt == DB_LAST) begin
                                byte_cnt <= '0;
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b1;
                                state    <= MEM_REQ;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end

                    MEM_REQ: begin
                        overrun <= rx_valid;
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            if (mem_we) begin
                                if (words_left != 8'd0) begin
                                    words_left <= words_left - 8'd1;
                                    mem_addr   <= mem_addr + 1'b1;
                                    state      <= GET_DATA;
                                end else begin
                                    tx_data  <= RSP_ACK;
                                    tx_valid <= 1'b1;
                                    state    <= SEND_RESP;
                                end
                            end else begin
                                rd_buf   <= mem_rdata;
                                tx_data  <= mem_rdata[7:0];
                                tx_valid <= 1'b1;
                                byte_cnt <= '0;
                                state    <= SEND_DATA;
                            end
                        end
                    end

                    SEND_DATA: begin
                        overrun <= rx_valid;
                        if (tx_ready) begin
                            if (byte_cnt == DB_LAST) begin
                                tx_valid <= 1'b0;
                                byte_cnt <= '0;
                                if (words_left != 8'd0) begin
                                    words_left <= words_left - 8'd1;
                                    mem_addr   <= mem_addr + 1'b1;
                                    mem_req    <= 1'b1;
                                    state      <= MEM_REQ;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                                tx_data  <= rd_buf[(int'(byte_cnt) + 1)*8 +: 8];
                            end
                        end
                    end

                    SEND_RESP: begin
                        overrun <= rx_valid;
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_cmd_bridge.sv
// ============================================================================
// tb_uart_mem_cmd_bridge : scoreboard bench for uart_mem_cmd_bridge
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_mem_cmd_bridge;

    localparam int AW = 23;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        overrun;

    uart_mem_cmd_bridge #(
        .ADDR_BYTES(4), .ADDR_W(AW), .DATA_BYTES(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_L(rst_L),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .overrun(overrun)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } req_t;

    req_t       mem_q[$];
    logic [7:0] tx_q[$];
    int tests = 0;
    int fails = 0;
    int acks_done = 0;
    int ovr_seen = 0;
    int ovr_exp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: checks each request against the scoreboard, acks after a random delay.
    initial begin
        req_t cur;
        bit   pending = 0;
        int   dly = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_L) begin
                pending = 0;
            end else if (pending) begin
                if (dly == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.we ? $urandom : cur.data;
                    pending   = 0;
                    acks_done++;
                end else begin
                    dly--;
                end
            end else if (mem_req) begin
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_mem_req: got addr 0x%0h we %0d, expected none", mem_addr, mem_we);
                    cur = '{1'b1, '0, '0};
                end else begin
                    cur = mem_q.pop_front();
                    check("mem_we", 64'(mem_we), 64'(cur.we));
                    check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                    if (cur.we) check("mem_wdata", 64'(mem_wdata), 64'(cur.data));
                end
                pending = 1;
                dly = $urandom_range(0, 3);
            end
        end
    end

    // Transmit side: random backpressure, every transfer popped from the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            tx_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (rst_L && tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx: got 0x%0h, expected none", tx_data);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_byte", 64'(tx_data), 64'(e));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (overrun) ovr_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] len, input logic [31:0] a);
        send_byte(op);
        send_byte(len);
        for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    endtask

    task automatic wait_ack(input int prev);
        int n = 0;
        while (acks_done == prev && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (acks_done == prev) begin
            tests++;
            fails++;
            $display("FAIL ack_wait: got no mem_ack after %0d cycles, expected one", n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || tx_q.size() != 0 || mem_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("busy_after_frame", 64'(busy), 64'(0));
        check("mem_q_left", 64'(mem_q.size()), 64'(0));
        check("tx_q_left", 64'(tx_q.size()), 64'(0));
        mem_q.delete();
        tx_q.delete();
    endtask

    task automatic do_write(input int len, input logic [31:0] a, input bit fixed, input logic [31:0] fd);
        logic [31:0] dq[$];
        logic [31:0] d;
        int prev;
        for (int w = 0; w <= len; w++) begin
            d = fixed ? fd : $urandom;
            dq.push_back(d);
            mem_q.push_back('{1'b1, a[AW-1:0] + AW'(w), d});
        end
        tx_q.push_back(8'hA5);
        send_hdr(8'h56, 8'(len), a);
        for (int w = 0; w <= len; w++) begin
            prev = acks_done;
            for (int k = 0; k < 4; k++) send_byte(dq[w][8*k +: 8]);
            if (w < len) wait_ack(prev);
        end
        wait_idle();
    endtask

    task automatic do_read(input int len, input logic [31:0] a, input bit fixed, input logic [31:0] fd,
                           input bit inject);
        logic [31:0] d;
        int n;
        for (int w = 0; w <= len; w++) begin
            d = fixed ? fd : $urandom;
            mem_q.push_back('{1'b0, a[AW-1:0] + AW'(w), d});
            for (int k = 0; k < 4; k++) tx_q.push_back(d[8*k +: 8]);
        end
        send_hdr(8'h55, 8'(len), a);
        if (inject) begin
            n = 0;
            while (!tx_valid && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("tx_valid_before_inject", 64'(tx_valid), 64'(1));
            @(negedge clk);
            if (tx_valid) begin
                rx_data  = $urandom;
                rx_valid = 1'b1;
                ovr_exp++;
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        wait_idle();
        check("overrun_count", 64'(ovr_seen), 64'(ovr_exp));
    endtask

    task automatic do_nak(input logic [7:0] b);
        tx_q.push_back(8'hEE);
        send_byte(b);
        wait_idle();
    endtask

    task automatic check_reset_values();
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
    endtask

    initial begin
        #1800000;
        $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  b;
        int          kind;
        int          len;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_L = 1'b1;
        repeat (2) @(negedge clk);

        do_write(0, 32'h0000_0030, 1, 32'h00FF_00FF);
        do_read(0, 32'h0000_0030, 1, 32'h00FF_00FF, 0);
        do_write(1, 32'h007F_FFFF, 0, 32'h0);
        do_nak(8'h12);
        do_write(0, 32'h0000_0031, 0, 32'h0);
        do_read(1, 32'h0012_3456, 0, 32'h0, 1);
        do_write(2, 32'hFFFF_FFFE, 0, 32'h0);
        do_read(20, 32'h007F_FFF8, 0, 32'h0, 0);
        do_write(255, $urandom, 0, 32'h0);

`ifdef CMD_TIMEOUT_EN
        begin
            int n = 0;
            tx_q.push_back(8'hEE);
            send_byte(8'h56);
            send_byte(8'h00);
            send_byte(8'h30);
            send_byte(8'h00);
            while (!tx_valid && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("timeout_nak_window", 64'((n >= 90) && (n <= 110)), 64'(1));
            wait_idle();
        end
`endif

        // Reset partway through a write's data bytes.
        send_hdr(8'h56, 8'h00, 32'h0000_0444);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        #3;
        rst_L = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_L = 1'b1;
        do_write(0, 32'h0000_0444, 0, 32'h0);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            len  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            case (kind)
                0, 1:    do_write(len, $urandom, 0, 32'h0);
                2, 3:    do_read(len, $urandom, 0, 32'h0, ($urandom_range(0, 2) == 0));
                default: begin
                    do b = 8'($urandom); while (b == 8'h55 || b == 8'h56);
                    do_nak(b);
                end
            endcase
        end

        check("final_overrun_count", 64'(ovr_seen), 64'(ovr_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_mem_cmd_bridge.md
# uart_mem_cmd_bridge

Parametrised byte-stream command engine between the UART receiver/transmitter and the async Micron CellularRAM controller request port. It parses framed write (0x56) and read (0x55) commands with a burst length, issues one memory request per word with auto-incrementing address, and returns an ACK byte or the read data over UART. It succeeds the fixed 4-byte-address/4-byte-data single-word command path, adding configurable widths, bursts, NAK on bad opcodes, overrun flagging and an optional inter-byte timeout.

## Interface
- ADDR_BYTES, 4: address bytes per frame, LSB first; bits above ADDR_W are discarded.
- ADDR_W, 23: memory word-address width.
- DATA_BYTES, 4: bytes per memory word, LSB first.
- TIMEOUT_CYCLES, 500000: inter-byte timeout in clocks (used only with CMD_TIMEOUT_EN).
- clk  in  1  system clock (50 MHz).
- rst_L  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse, rx_data holds a received byte; no backpressure.
- rx_data  in  8  received byte.
- tx_valid  out  1  byte offered to UART transmitter.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  transmitter can accept; transfer when tx_valid & tx_ready.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  word address; stable while mem_req.
- mem_wdata  out  8*DATA_BYTES  write data; stable while mem_req.
- mem_rdata  in  8*DATA_BYTES  read data, valid on mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  one-cycle pulse when an rx byte is dropped.

## Operation
- Frame: opcode, LEN (word count = LEN+1, 1..256), ADDR_BYTES address bytes, then for write (LEN+1)*DATA_BYTES data bytes.
- States: IDLE, GET_LEN, GET_ADDR, GET_DATA, MEM_REQ, SEND_DATA, SEND_RESP.
- IDLE: rx 0x56/0x55 -> GET_LEN (latch opcode); any other byte -> SEND_RESP with 0xEE (NAK).
- GET_LEN -> GET_ADDR after one byte; GET_ADDR -> GET_DATA (write) or MEM_REQ (read) after ADDR_BYTES bytes.
- GET_DATA: after DATA_BYTES bytes -> MEM_REQ (write). After ack: if words remain, address+1, -> GET_DATA; else -> SEND_RESP with 0xA5 (ACK).
- Read MEM_REQ: on ack capture mem_rdata -> SEND_DATA; send DATA_BYTES bytes LSB first; then address+1 and MEM_REQ if words remain, else IDLE (no ACK byte on reads).
- SEND_RESP: holds tx_valid until tx_ready, then IDLE.
- Address increment wraps modulo 2^ADDR_W.
- rx_valid in MEM_REQ, SEND_DATA or SEND_RESP: byte dropped, overrun pulses, state unaffected.
- Reset mid-frame: all state and counters cleared immediately, in-flight mem_req dropped; the memory controller is reset by the same rst_L.

## Timing
- Reset values: tx_valid 0, tx_data 0x00, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, overrun 0.
- mem_req rises the cycle after the last word byte is registered; it falls the cycle after mem_ack. mem_req is low for at least one cycle between requests.
- tx_valid rises the cycle after entering SEND_*; the next byte is presented the cycle after each transfer.
- busy rises the cycle after the opcode byte and falls the cycle after the final transfer.
- rx byte and mem_ack in the same cycle (read): ack is taken, byte is dropped, overrun pulses.

## Configuration
- CMD_TIMEOUT_EN defined: a counter reloads on each accepted byte in GET_LEN/GET_ADDR/GET_DATA. On reaching TIMEOUT_CYCLES, the bridge abandons the frame and goes to SEND_RESP with 0xEE. Memory words already written stay written.
- CMD_TIMEOUT_EN undefined: no counter; a partial frame waits indefinitely.

## Test plan
- Write 56 00 30 00 00 00 FF 00 FF 00 -> one mem_req with mem_we=1, mem_addr=0x000030, mem_wdata=0x00FF00FF; tx 0xA5; busy low afterwards.
- Read 55 00 30 00 00 00, mem_rdata=0x00FF00FF -> mem_addr=0x000030, we=0; tx bytes FF 00 FF 00 in order; no ACK byte.
- Burst write LEN=0x01 at 0x7FFFFF (ADDR bytes FF FF 7F 00) -> writes to 0x7FFFFF then 0x000000 (wrap); single 0xA5.
- Opcode 0x12 -> tx 0xEE, no mem_req; a following valid write frame completes normally.
- Byte injected during read SEND_DATA -> overrun pulse, response bytes unchanged. With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, stopping after two address bytes -> 0xEE after 100 idle cycles.
- rst_L low mid GET_DATA -> all outputs at reset values at once; a fresh write frame then completes with 0xA5.
